// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: decoded control bundle pipeline (E..W) with per-stage stall/flush, valid tracking, multi-cycle stage-0 hold and retire counter; ports: ctrl_d/valid_d/mc_d in, stall/flush per stage, ctrl_o/valid_o per stage, hold_d_o, mc_busy_o, retire_cnt_o
module ctrl_pipeline #(
    parameter int CTRL_W    = 16,
    parameter int N_STAGES  = 3,
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CTRL_W-1:0]            ctrl_d,
    input  logic                         valid_d,
    input  logic                         mc_d,
    input  logic [N_STAGES-1:0]          stall,
    input  logic [N_STAGES-1:0]          flush,
    output logic [N_STAGES*CTRL_W-1:0]   ctrl_o,
    output logic [N_STAGES-1:0]          valid_o,
    output logic                         hold_d_o,
    output logic                         mc_busy_o,
    output logic [CNT_W-1:0]             retire_cnt_o
);
    localparam int MCW = $clog2(MC_CYCLES) + 1;

    logic [N_STAGES-1:0][CTRL_W-1:0] st_ctrl_q, st_ctrl_d;
    logic [N_STAGES-1:0]             st_valid_q, st_valid_d, h;
    logic [MCW-1:0]                  mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]                retire_q, retire_d;
    logic                            mc_busy;

    assign mc_busy = mc_cnt_q != '0;

    always_comb begin
        logic [N_STAGES-1:0] c;
        c = '0;
        c[N_STAGES-1] = stall[N_STAGES-1];
        for (int k = N_STAGES - 2; k >= 0; k--) c[k] = stall[k] | c[k+1];
        c[0] = c[0] | mc_busy;
        h = c;
    end

    always_comb begin
        st_ctrl_d     = st_ctrl_q;
        st_valid_d    = st_valid_q;
        st_ctrl_d[0]  = flush[0] ? '0   : h[0] ? st_ctrl_q[0]  : ctrl_d;
        st_valid_d[0] = flush[0] ? 1'b0 : h[0] ? st_valid_q[0] : valid_d;
        for (int k = 1; k < N_STAGES; k++) begin
            st_ctrl_d[k]  = (flush[k] || (!h[k] && h[k-1])) ? '0   : h[k] ? st_ctrl_q[k]  : st_ctrl_q[k-1];
            st_valid_d[k] = (flush[k] || (!h[k] && h[k-1])) ? 1'b0 : h[k] ? st_valid_q[k] : st_valid_q[k-1];
        end
        mc_cnt_d = flush[0] ? '0 :
                   mc_busy  ? mc_cnt_q - MCW'(1) :
                   (!h[0] && valid_d && mc_d) ? MCW'(MC_CYCLES - 1) : '0;
        retire_d = retire_q + CNT_W'(st_valid_q[N_STAGES-1] & ~h[N_STAGES-1] & ~flush[N_STAGES-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_ctrl_q  <= '0;
            st_valid_q <= '0;
            mc_cnt_q   <= '0;
            retire_q   <= '0;
        end else begin
            st_ctrl_q  <= st_ctrl_d;
            st_valid_q <= st_valid_d;
            mc_cnt_q   <= mc_cnt_d;
            retire_q   <= retire_d;
        end
    end

    assign ctrl_o       = st_ctrl_q;
    assign valid_o      = st_valid_q;
    assign hold_d_o     = h[0];
    assign mc_busy_o    = mc_busy;
    assign retire_cnt_o = retire_q;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed vector table plus wrap/MC_CYCLES=1 sequence for ctrl_pipeline
module tb_ctrl_pipeline;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ctrl_d;
    logic        valid_d, mc_d;
    logic [2:0]  stall, flush;
    logic [47:0] ctrl_o, w_ctrl;
    logic [2:0]  valid_o, w_valid;
    logic        hold_d_o, mc_busy_o, w_hold, w_busy;
    logic [31:0] retire_cnt_o;
    logic [3:0]  w_ret;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ctrl_pipeline dut (
        .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .valid_d(valid_d), .mc_d(mc_d),
        .stall(stall), .flush(flush), .ctrl_o(ctrl_o), .valid_o(valid_o),
        .hold_d_o(hold_d_o), .mc_busy_o(mc_busy_o), .retire_cnt_o(retire_cnt_o)
    );

    ctrl_pipeline #(.MC_CYCLES(1), .CNT_W(4)) u_w (
        .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .valid_d(valid_d), .mc_d(mc_d),
        .stall(stall), .flush(flush), .ctrl_o(w_ctrl), .valid_o(w_valid),
        .hold_d_o(w_hold), .mc_busy_o(w_busy), .retire_cnt_o(w_ret)
    );

    typedef struct {
        logic        rst;
        logic [15:0] c;
        logic        v, m;
        logic [2:0]  st, fl;
        logic        hold;
        logic [47:0] eo;
        logic [2:0]  ev;
        logic        busy;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [15:0] c, logic v, logic m, logic [2:0] st, logic [2:0] fl,
                                logic hold, logic [15:0] s2, logic [15:0] s1, logic [15:0] s0,
                                logic [2:0] ev, logic busy, logic [31:0] ret);
        vec_t t;
        t.rst = r; t.c = c; t.v = v; t.m = m; t.st = st; t.fl = fl; t.hold = hold;
        t.eo = {s2, s1, s0}; t.ev = ev; t.busy = busy; t.ret = ret;
        return t;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [15:0] c, logic v, logic m, logic [2:0] st, logic [2:0] fl);
        rst = r; ctrl_d = c; valid_d = v; mc_d = m; stall = st; flush = fl;
    endtask

    initial begin
        drive(1, 16'h0, 0, 0, 3'b000, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset ctrl", 64'(ctrl_o), 64'h0);
        chk("reset valid", 64'(valid_o), 64'h0);
        chk("reset busy", 64'(mc_busy_o), 64'h0);
        chk("reset retire", 64'(retire_cnt_o), 64'h0);
        chk("reset hold", 64'(hold_d_o), 64'h0);
        // straight flow
        tbl.push_back(mk(0, 16'hA001, 1, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'hA001, 3'b001, 0, 0));
        tbl.push_back(mk(0, 16'hA002, 1, 0, 3'b000, 3'b000, 0, 16'h0,    16'hA001, 16'hA002, 3'b011, 0, 0));
        tbl.push_back(mk(0, 16'hA003, 1, 0, 3'b000, 3'b000, 0, 16'hA001, 16'hA002, 16'hA003, 3'b111, 0, 0));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'hA002, 16'hA003, 16'h0,    3'b110, 0, 1));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'hA003, 16'h0,    16'h0,    3'b100, 0, 2));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'h0,    3'b000, 0, 3));
        // middle stall
        tbl.push_back(mk(0, 16'hB000, 1, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'hB000, 3'b001, 0, 3));
        tbl.push_back(mk(0, 16'hB001, 1, 0, 3'b000, 3'b000, 0, 16'h0,    16'hB000, 16'hB001, 3'b011, 0, 3));
        tbl.push_back(mk(0, 16'hB002, 1, 0, 3'b000, 3'b000, 0, 16'hB000, 16'hB001, 16'hB002, 3'b111, 0, 3));
        tbl.push_back(mk(0, 16'hB003, 1, 0, 3'b010, 3'b000, 1, 16'h0,    16'hB001, 16'hB002, 3'b011, 0, 4));
        tbl.push_back(mk(0, 16'hB003, 1, 0, 3'b010, 3'b000, 1, 16'h0,    16'hB001, 16'hB002, 3'b011, 0, 4));
        tbl.push_back(mk(0, 16'hB003, 1, 0, 3'b000, 3'b000, 0, 16'hB001, 16'hB002, 16'hB003, 3'b111, 0, 4));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'hB002, 16'hB003, 16'h0,    3'b110, 0, 5));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'hB003, 16'h0,    16'h0,    3'b100, 0, 6));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'h0,    3'b000, 0, 7));
        // multi-cycle hold
        tbl.push_back(mk(0, 16'hC001, 1, 1, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'hC001, 3'b001, 1, 7));
        tbl.push_back(mk(0, 16'hC002, 1, 0, 3'b000, 3'b000, 1, 16'h0,    16'h0,    16'hC001, 3'b001, 1, 7));
        tbl.push_back(mk(0, 16'hC002, 1, 0, 3'b000, 3'b000, 1, 16'h0,    16'h0,    16'hC001, 3'b001, 1, 7));
        tbl.push_back(mk(0, 16'hC002, 1, 0, 3'b000, 3'b000, 1, 16'h0,    16'h0,    16'hC001, 3'b001, 0, 7));
        tbl.push_back(mk(0, 16'hC002, 1, 0, 3'b000, 3'b000, 0, 16'h0,    16'hC001, 16'hC002, 3'b011, 0, 7));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'hC001, 16'hC002, 16'h0,    3'b110, 0, 7));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'hC002, 16'h0,    16'h0,    3'b100, 0, 8));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'h0,    3'b000, 0, 9));
        // flush during mc hold
        tbl.push_back(mk(0, 16'hC001, 1, 1, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'hC001, 3'b001, 1, 9));
        tbl.push_back(mk(0, 16'hC002, 1, 0, 3'b000, 3'b000, 1, 16'h0,    16'h0,    16'hC001, 3'b001, 1, 9));
        tbl.push_back(mk(0, 16'hC002, 1, 0, 3'b000, 3'b001, 1, 16'h0,    16'h0,    16'h0,    3'b000, 0, 9));
        tbl.push_back(mk(0, 16'hC002, 1, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'hC002, 3'b001, 0, 9));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'h0,    16'hC002, 16'h0,    3'b010, 0, 9));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'hC002, 16'h0,    16'h0,    3'b100, 0, 9));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'h0,    3'b000, 0, 10));
        // flush beats stall at stage 0
        tbl.push_back(mk(0, 16'hD100, 1, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'hD100, 3'b001, 0, 10));
        tbl.push_back(mk(0, 16'hD200, 1, 0, 3'b000, 3'b000, 0, 16'h0,    16'hD100, 16'hD200, 3'b011, 0, 10));
        tbl.push_back(mk(0, 16'hD001, 1, 0, 3'b000, 3'b000, 0, 16'hD100, 16'hD200, 16'hD001, 3'b111, 0, 10));
        tbl.push_back(mk(0, 16'hD002, 1, 0, 3'b001, 3'b001, 1, 16'hD200, 16'h0,    16'h0,    3'b100, 0, 11));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'h0,    3'b000, 0, 12));
        // stall stage 0 with flush of stage 1
        tbl.push_back(mk(0, 16'hE001, 1, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'hE001, 3'b001, 0, 12));
        tbl.push_back(mk(0, 16'hE002, 1, 0, 3'b000, 3'b000, 0, 16'h0,    16'hE001, 16'hE002, 3'b011, 0, 12));
        tbl.push_back(mk(0, 16'hE003, 1, 0, 3'b001, 3'b010, 1, 16'hE001, 16'h0,    16'hE002, 3'b101, 0, 12));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'h0,    16'hE002, 16'h0,    3'b010, 0, 13));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'hE002, 16'h0,    16'h0,    3'b100, 0, 13));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'h0,    3'b000, 0, 14));
        // reset during mc hold with last-stage stall
        tbl.push_back(mk(0, 16'h1111, 1, 1, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'h1111, 3'b001, 1, 14));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b100, 3'b000, 1, 16'h0,    16'h0,    16'h1111, 3'b001, 1, 14));
        tbl.push_back(mk(1, 16'h2222, 1, 1, 3'b100, 3'b000, 1, 16'h0,    16'h0,    16'h0,    3'b000, 0, 0));
        tbl.push_back(mk(0, 16'h0,    0, 0, 3'b000, 3'b000, 0, 16'h0,    16'h0,    16'h0,    3'b000, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].c, tbl[i].v, tbl[i].m, tbl[i].st, tbl[i].fl);
            #1;
            chk($sformatf("r%0d hold", i + 1), 64'(hold_d_o), 64'(tbl[i].hold));
            @(posedge clk);
            #1;
            chk($sformatf("r%0d ctrl", i + 1), 64'(ctrl_o), 64'(tbl[i].eo));
            chk($sformatf("r%0d valid", i + 1), 64'(valid_o), 64'(tbl[i].ev));
            chk($sformatf("r%0d busy", i + 1), 64'(mc_busy_o), 64'(tbl[i].busy));
            chk($sformatf("r%0d retire", i + 1), 64'(retire_cnt_o), 64'(tbl[i].ret));
        end
        // narrow counter wrap and MC_CYCLES=1 never holding
        drive(1, 16'h0, 0, 0, 3'b000, 3'b000);
        @(posedge clk);
        #1;
        chk("wrap reset", 64'(w_ret), 64'h0);
        for (int n = 1; n <= 19; n++) begin
            drive(0, 16'(n), 1, 1, 3'b000, 3'b000);
            #1;
            chk($sformatf("w%0d hold", n), 64'(w_hold), 64'h0);
            @(posedge clk);
            #1;
            chk($sformatf("w%0d busy", n), 64'(w_busy), 64'h0);
            chk($sformatf("w%0d retire", n), 64'(w_ret), 64'(n >= 4 ? (n - 3) % 16 : 0));
            if (n >= 3) chk($sformatf("w%0d stage2", n), 64'(w_ctrl[47:32]), 64'(n - 2));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
